// File: rtl/vram_arbiter.sv
// Shares one VRAM controller between video, CPU and command requesters,
// inserting periodic auto-refreshes and returning read data to the owning port.
module vram_arbiter #(
   parameter int FREQ             = 54_000_000,
   parameter int REFRESH_INTERVAL = 405
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        vid_req,
   input  logic [22:0] vid_addr,
   input  logic [1:0]  vid_size,
   output logic        vid_ack,
   output logic        vid_valid,
   output logic [31:0] vid_data,

   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [22:0] cpu_addr,
   input  logic [7:0]  cpu_din8,
   output logic        cpu_ack,
   output logic        cpu_valid,
   output logic [7:0]  cpu_data,

   input  logic        cmd_req,
   input  logic        cmd_wr,
   input  logic [22:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [7:0]  cmd_din8,
   input  logic [31:0] cmd_din32,
   output logic        cmd_ack,
   output logic        cmd_valid,
   output logic [31:0] cmd_data,

   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_refresh,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_word_size,
   output logic [7:0]  mem_din8,
   output logic [31:0] mem_din32,
   input  logic        mem_busy,
   input  logic        mem_enabled,
   input  logic [15:0] mem_dout16,
   input  logic [31:0] mem_dout32,

   output logic        refresh_overrun
);

   // FREQ is informational; a degenerate clock or interval collapses the counter to one bit.
   localparam int CNT_W = (FREQ > 0 && REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VID,
      OWN_CPU,
      OWN_CMD
   } owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              cpu_last_q, cpu_last_d;
   logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
   logic              ref_pend_q, ref_pend_d;
   logic              overrun_q, overrun_d;
   logic              ref_wrap, issue_refresh;

   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_refresh_q, mem_refresh_d;
   logic [22:0]       mem_addr_q, mem_addr_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic [7:0]        mem_din8_q, mem_din8_d;
   logic [31:0]       mem_din32_q, mem_din32_d;

   logic              vid_ack_q, vid_ack_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              cmd_ack_q, cmd_ack_d;
   logic              vid_valid_q, vid_valid_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [31:0]       vid_data_q, vid_data_d;
   logic [7:0]        cpu_data_q, cpu_data_d;
   logic [31:0]       cmd_data_q, cmd_data_d;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      cpu_last_d    = cpu_last_q;
      issue_refresh = 1'b0;

      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_refresh_d = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_size_d    = mem_size_q;
      mem_din8_d    = mem_din8_q;
      mem_din32_d   = mem_din32_q;

      vid_ack_d     = 1'b0;
      cpu_ack_d     = 1'b0;
      cmd_ack_d     = 1'b0;
      vid_valid_d   = 1'b0;
      cpu_valid_d   = 1'b0;
      cmd_valid_d   = 1'b0;
      vid_data_d    = vid_data_q;
      cpu_data_d    = cpu_data_q;
      cmd_data_d    = cmd_data_q;

      ref_wrap  = (ref_cnt_q == CNT_LAST);
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (!mem_busy && mem_enabled) begin
               if (vid_req) begin
                  mem_read_d = 1'b1;
                  vid_ack_d  = 1'b1;
                  mem_addr_d = vid_addr;
                  mem_size_d = vid_size;
                  owner_d    = OWN_VID;
                  state_d    = S_WAIT;
               end else if (ref_pend_q) begin
                  mem_refresh_d = 1'b1;
                  issue_refresh = 1'b1;
                  owner_d       = OWN_NONE;
                  state_d       = S_WAIT;
               end else if (cmd_req && (cpu_last_q || !cpu_req)) begin
                  cmd_ack_d   = 1'b1;
                  cpu_last_d  = 1'b0;
                  mem_addr_d  = cmd_addr;
                  mem_din8_d  = cmd_din8;
                  mem_din32_d = cmd_din32;
                  state_d     = S_WAIT;
                  if (cmd_wr) begin
                     // A 16-bit command write is really a byte write on the controller.
                     mem_write_d = 1'b1;
                     mem_size_d  = (cmd_size == 2'b01) ? 2'b00 : cmd_size;
                     owner_d     = OWN_NONE;
                  end else begin
                     mem_read_d = 1'b1;
                     mem_size_d = cmd_size;
                     owner_d    = OWN_CMD;
                  end
               end else if (cpu_req) begin
                  cpu_ack_d  = 1'b1;
                  cpu_last_d = 1'b1;
                  mem_addr_d = cpu_addr;
                  state_d    = S_WAIT;
                  if (cpu_wr) begin
                     mem_write_d = 1'b1;
                     mem_size_d  = 2'b00;
                     mem_din8_d  = cpu_din8;
                     owner_d     = OWN_NONE;
                  end else begin
                     mem_read_d = 1'b1;
                     mem_size_d = 2'b01;
                     owner_d    = OWN_CPU;
                  end
               end
            end
         end
         S_WAIT: begin
            if (!mem_busy) begin
               state_d = S_IDLE;
               owner_d = OWN_NONE;
               case (owner_q)
                  OWN_VID: begin
                     vid_data_d  = mem_dout32;
                     vid_valid_d = 1'b1;
                  end
                  OWN_CPU: begin
                     cpu_data_d  = mem_addr_q[0] ? mem_dout16[15:8] : mem_dout16[7:0];
                     cpu_valid_d = 1'b1;
                  end
                  OWN_CMD: begin
                     cmd_data_d  = mem_dout32;
                     cmd_valid_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase

      ref_pend_d = ref_pend_q;
      if (issue_refresh)
         ref_pend_d = 1'b0;
      if (ref_wrap)
         ref_pend_d = 1'b1;
      overrun_d = overrun_q | (ref_wrap & ref_pend_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_NONE;
         cpu_last_q    <= 1'b1;
         ref_cnt_q     <= '0;
         ref_pend_q    <= 1'b0;
         overrun_q     <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_refresh_q <= 1'b0;
         mem_addr_q    <= '0;
         mem_size_q    <= '0;
         mem_din8_q    <= '0;
         mem_din32_q   <= '0;
         vid_ack_q     <= 1'b0;
         cpu_ack_q     <= 1'b0;
         cmd_ack_q     <= 1'b0;
         vid_valid_q   <= 1'b0;
         cpu_valid_q   <= 1'b0;
         cmd_valid_q   <= 1'b0;
         vid_data_q    <= '0;
         cpu_data_q    <= '0;
         cmd_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         cpu_last_q    <= cpu_last_d;
         ref_cnt_q     <= ref_cnt_d;
         ref_pend_q    <= ref_pend_d;
         overrun_q     <= overrun_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_refresh_q <= mem_refresh_d;
         mem_addr_q    <= mem_addr_d;
         mem_size_q    <= mem_size_d;
         mem_din8_q    <= mem_din8_d;
         mem_din32_q   <= mem_din32_d;
         vid_ack_q     <= vid_ack_d;
         cpu_ack_q     <= cpu_ack_d;
         cmd_ack_q     <= cmd_ack_d;
         vid_valid_q   <= vid_valid_d;
         cpu_valid_q   <= cpu_valid_d;
         cmd_valid_q   <= cmd_valid_d;
         vid_data_q    <= vid_data_d;
         cpu_data_q    <= cpu_data_d;
         cmd_data_q    <= cmd_data_d;
      end
   end

   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_refresh     = mem_refresh_q;
   assign mem_addr        = mem_addr_q;
   assign mem_word_size   = mem_size_q;
   assign mem_din8        = mem_din8_q;
   assign mem_din32       = mem_din32_q;
   assign vid_ack         = vid_ack_q;
   assign cpu_ack         = cpu_ack_q;
   assign cmd_ack         = cmd_ack_q;
   assign vid_valid       = vid_valid_q;
   assign cpu_valid       = cpu_valid_q;
   assign cmd_valid       = cmd_valid_q;
   assign vid_data        = vid_data_q;
   assign cpu_data        = cpu_data_q;
   assign cmd_data        = cmd_data_q;
   assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a default-interval instance for data paths and
// arbitration, and an 8-cycle-interval instance for refresh starvation.
module tb_vram_arbiter;

   localparam int BUSY_LEN = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        vid_req = 0, cpu_req = 0, cpu_wr = 0, cmd_req = 0, cmd_wr = 0;
   logic [22:0] vid_addr = '0, cpu_addr = '0, cmd_addr = '0;
   logic [1:0]  vid_size = '0, cmd_size = '0;
   logic [7:0]  cpu_din8 = '0, cmd_din8 = '0;
   logic [31:0] cmd_din32 = '0;
   logic        mem_enabled = 1'b1;
   logic [15:0] mem_dout16 = '0;
   logic [31:0] mem_dout32 = '0;

   logic        vid_ack, vid_valid, cpu_ack, cpu_valid, cmd_ack, cmd_valid;
   logic [31:0] vid_data, cmd_data;
   logic [7:0]  cpu_data;
   logic        mem_read, mem_write, mem_refresh, mem_busy, refresh_overrun;
   logic [22:0] mem_addr;
   logic [1:0]  mem_word_size;
   logic [7:0]  mem_din8;
   logic [31:0] mem_din32;

   logic        r_vid_ack, r_vid_valid, r_cpu_ack, r_cpu_valid, r_cmd_ack, r_cmd_valid;
   logic [31:0] r_vid_data, r_cmd_data;
   logic [7:0]  r_cpu_data;
   logic        r_mem_read, r_mem_write, r_mem_refresh, r_mem_busy, r_overrun;
   logic [22:0] r_mem_addr;
   logic [1:0]  r_mem_word_size;
   logic [7:0]  r_mem_din8;
   logic [31:0] r_mem_din32;

   int vectors = 0;
   int errors  = 0;
   int m_cnt = 0, r_cnt = 0;

   // Controller model: busy from the strobe cycle for BUSY_LEN cycles.
   assign mem_busy   = mem_read | mem_write | mem_refresh | (m_cnt != 0);
   assign r_mem_busy = r_mem_read | r_mem_write | r_mem_refresh | (r_cnt != 0);

   always @(posedge clk or posedge reset) begin
      if (reset) m_cnt <= 0;
      else if (mem_read | mem_write | mem_refresh) m_cnt <= BUSY_LEN - 1;
      else if (m_cnt != 0) m_cnt <= m_cnt - 1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) r_cnt <= 0;
      else if (r_mem_read | r_mem_write | r_mem_refresh) r_cnt <= BUSY_LEN - 1;
      else if (r_cnt != 0) r_cnt <= r_cnt - 1;
   end

   vram_arbiter u_dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_size(vid_size),
      .vid_ack(vid_ack), .vid_valid(vid_valid), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din8(cpu_din8),
      .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
      .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
      .cmd_din8(cmd_din8), .cmd_din32(cmd_din32),
      .cmd_ack(cmd_ack), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
      .mem_addr(mem_addr), .mem_word_size(mem_word_size),
      .mem_din8(mem_din8), .mem_din32(mem_din32),
      .mem_busy(mem_busy), .mem_enabled(mem_enabled),
      .mem_dout16(mem_dout16), .mem_dout32(mem_dout32),
      .refresh_overrun(refresh_overrun)
   );

   vram_arbiter #(.REFRESH_INTERVAL(8)) u_ref (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_size(vid_size),
      .vid_ack(r_vid_ack), .vid_valid(r_vid_valid), .vid_data(r_vid_data),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din8(cpu_din8),
      .cpu_ack(r_cpu_ack), .cpu_valid(r_cpu_valid), .cpu_data(r_cpu_data),
      .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
      .cmd_din8(cmd_din8), .cmd_din32(cmd_din32),
      .cmd_ack(r_cmd_ack), .cmd_valid(r_cmd_valid), .cmd_data(r_cmd_data),
      .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_refresh(r_mem_refresh),
      .mem_addr(r_mem_addr), .mem_word_size(r_mem_word_size),
      .mem_din8(r_mem_din8), .mem_din32(r_mem_din32),
      .mem_busy(r_mem_busy), .mem_enabled(mem_enabled),
      .mem_dout16(mem_dout16), .mem_dout32(mem_dout32),
      .refresh_overrun(r_overrun)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset;
      vid_req = 1; cpu_req = 1; cmd_req = 1; vid_addr = 23'h123; vid_size = 2'b10;
      reset = 1'b1;
      tick; tick;
      vectors++;
      if ({mem_read, mem_write, mem_refresh} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes: got %b exp 000", {mem_read, mem_write, mem_refresh});
      end
      vectors++;
      if ({vid_ack, cpu_ack, cmd_ack, vid_valid, cpu_valid, cmd_valid} !== 6'b0) begin
         errors++; $display("FAIL reset_ack_valid: got %b exp 000000",
                            {vid_ack, cpu_ack, cmd_ack, vid_valid, cpu_valid, cmd_valid});
      end
      vectors++;
      if ({mem_addr, mem_word_size, mem_din8, mem_din32} !== 65'b0) begin
         errors++; $display("FAIL reset_mem_bus: got addr %h size %b din8 %h din32 %h exp 0",
                            mem_addr, mem_word_size, mem_din8, mem_din32);
      end
      vectors++;
      if ({vid_data, cpu_data, cmd_data, refresh_overrun} !== 73'b0) begin
         errors++; $display("FAIL reset_data: got vid %h cpu %h cmd %h ovr %b exp 0",
                            vid_data, cpu_data, cmd_data, refresh_overrun);
      end
      vid_req = 0; cpu_req = 0; cmd_req = 0;
      tick;
      reset = 1'b0;
   endtask

   task automatic test_vid_read;
      int seen;
      logic found;
      logic exp_v;
      do_reset;
      mem_enabled = 0;
      mem_dout32 = 32'hDEADBEEF;
      vid_req = 1; vid_addr = 23'h000100; vid_size = 2'b10;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (mem_read | mem_write | mem_refresh) seen++;
      end
      vectors++;
      if (seen != 0) begin
         errors++; $display("FAIL enable_gate: got %0d issues exp 0", seen);
      end
      mem_enabled = 1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick;
         if (mem_read) found = 1;
      end
      vectors++;
      if (!found) begin
         errors++; $display("FAIL vid_issue: got timeout exp mem_read");
      end else begin
         vectors++;
         if ({vid_ack, mem_addr, mem_word_size} !== {1'b1, 23'h000100, 2'b10}) begin
            errors++; $display("FAIL vid_issue_fields: got ack %b addr %h size %b exp 1 000100 10",
                               vid_ack, mem_addr, mem_word_size);
         end
      end
      vid_req = 0;
      for (int k = 1; k <= 6; k++) begin
         tick;
         exp_v = (k == 5);
         vectors++;
         if (vid_valid !== exp_v) begin
            errors++; $display("FAIL vid_valid_t%0d: got %b exp %b", k, vid_valid, exp_v);
         end
         if (k >= 5) begin
            vectors++;
            if (vid_data !== 32'hDEADBEEF) begin
               errors++; $display("FAIL vid_data_t%0d: got %h exp deadbeef", k, vid_data);
            end
         end
      end
   endtask

   task automatic test_cpu_read;
      logic [22:0] addr_tab [2];
      logic [7:0]  exp_tab  [2];
      logic found;
      int lat;
      addr_tab[0] = 23'h000005; exp_tab[0] = 8'hA5;
      addr_tab[1] = 23'h000004; exp_tab[1] = 8'h5A;
      do_reset;
      mem_dout16 = 16'hA55A;
      for (int t = 0; t < 2; t++) begin
         cpu_req = 1; cpu_wr = 0; cpu_addr = addr_tab[t];
         found = 0;
         for (int i = 0; i < 12 && !found; i++) begin
            tick;
            if (mem_read) found = 1;
         end
         vectors++;
         if (!found || {cpu_ack, mem_word_size, mem_addr} !== {1'b1, 2'b01, addr_tab[t]}) begin
            errors++; $display("FAIL cpu_issue%0d: got found %b ack %b size %b addr %h exp 1 1 01 %h",
                               t, found, cpu_ack, mem_word_size, mem_addr, addr_tab[t]);
         end
         cpu_req = 0;
         lat = 0;
         found = 0;
         for (int i = 0; i < 12 && !found; i++) begin
            tick;
            lat++;
            if (cpu_valid) found = 1;
         end
         vectors++;
         if (!found || lat != 5 || cpu_data !== exp_tab[t]) begin
            errors++; $display("FAIL cpu_data%0d: got valid %b lat %0d data %h exp 1 5 %h",
                               t, found, lat, cpu_data, exp_tab[t]);
         end
      end
   endtask

   task automatic test_cmd;
      logic found;
      int vcount;
      do_reset;
      mem_dout32 = 32'h12345678;
      cmd_req = 1; cmd_wr = 0; cmd_size = 2'b10; cmd_addr = 23'h000040;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (mem_read) found = 1; end
      vectors++;
      if (!found || {cmd_ack, mem_word_size} !== 3'b110) begin
         errors++; $display("FAIL cmd_read_issue: got found %b ack %b size %b exp 1 1 10",
                            found, cmd_ack, mem_word_size);
      end
      cmd_req = 0;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (cmd_valid) found = 1; end
      vectors++;
      if (!found || cmd_data !== 32'h12345678) begin
         errors++; $display("FAIL cmd_read_data: got valid %b data %h exp 1 12345678", found, cmd_data);
      end

      cmd_req = 1; cmd_wr = 1; cmd_size = 2'b01; cmd_din8 = 8'h3C; cmd_din32 = 32'hCAFEF00D;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (mem_write) found = 1; end
      vectors++;
      if (!found || {cmd_ack, mem_word_size, mem_din8} !== {1'b1, 2'b00, 8'h3C}) begin
         errors++; $display("FAIL cmd_write8: got found %b ack %b size %b din8 %h exp 1 1 00 3c",
                            found, cmd_ack, mem_word_size, mem_din8);
      end
      cmd_req = 0;
      tick;
      cmd_req = 1; cmd_size = 2'b10; cmd_din32 = 32'h0BADC0DE;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (mem_write) found = 1; end
      vectors++;
      if (!found || {mem_word_size, mem_din32} !== {2'b10, 32'h0BADC0DE}) begin
         errors++; $display("FAIL cmd_write32: got found %b size %b din32 %h exp 1 10 0badc0de",
                            found, mem_word_size, mem_din32);
      end
      cmd_req = 0;
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (vid_valid | cpu_valid | cmd_valid) vcount++;
      end
      vectors++;
      if (vcount != 0 || cmd_data !== 32'h12345678) begin
         errors++; $display("FAIL write_no_valid: got %0d valids data %h exp 0 12345678", vcount, cmd_data);
      end
   endtask

   // Runs straight after test_cmd so the command port was granted last.
   task automatic test_back_to_back;
      logic grants [4];
      int g, last_issue, cyc;
      logic prev_busy;
      logic strobe;
      grants[0] = 0; grants[1] = 0; grants[2] = 0; grants[3] = 0;
      cpu_req = 1; cpu_wr = 1; cpu_addr = 23'h000010; cpu_din8 = 8'h11;
      cmd_req = 1; cmd_wr = 1; cmd_size = 2'b10; cmd_din32 = 32'h55AA55AA;
      g = 0; last_issue = -100; cyc = 0; prev_busy = mem_busy;
      for (int i = 0; i < 60 && g < 4; i++) begin
         tick;
         cyc++;
         strobe = mem_read | mem_write | mem_refresh;
         if (strobe) begin
            vectors++;
            if (prev_busy !== 1'b0 || (cyc - last_issue) < 6) begin
               errors++; $display("FAIL rr_spacing%0d: got prev_busy %b gap %0d exp 0 >=6",
                                  g, prev_busy, cyc - last_issue);
            end
            last_issue = cyc;
         end
         if (cpu_ack | cmd_ack) begin
            grants[g] = cmd_ack;
            if (cpu_ack) begin
               vectors++;
               if ({mem_write, mem_word_size, mem_din8} !== {1'b1, 2'b00, 8'h11}) begin
                  errors++; $display("FAIL rr_cpu_write: got wr %b size %b din8 %h exp 1 00 11",
                                     mem_write, mem_word_size, mem_din8);
               end
            end
            g++;
         end
         prev_busy = mem_busy;
      end
      vectors++;
      if (g != 4 || {grants[0], grants[1], grants[2], grants[3]} !== 4'b0101) begin
         errors++; $display("FAIL rr_order: got %0d grants seq %b exp 4 0101 (0=cpu)",
                            g, {grants[0], grants[1], grants[2], grants[3]});
      end
      cpu_req = 0; cmd_req = 0;
      for (int i = 0; i < 8; i++) tick;
   endtask

   task automatic test_refresh_starvation;
      int refs, reads_after;
      logic found;
      do_reset;
      vid_req = 1; vid_addr = 23'h000200; vid_size = 2'b10;
      refs = 0;
      for (int k = 1; k <= 20; k++) begin
         tick;
         if (r_mem_refresh) refs++;
         if (k == 15) begin
            vectors++;
            if (r_overrun !== 1'b0) begin
               errors++; $display("FAIL overrun_early: got %b exp 0", r_overrun);
            end
         end
         if (k == 16) begin
            vectors++;
            if (r_overrun !== 1'b1) begin
               errors++; $display("FAIL overrun_set: got %b exp 1", r_overrun);
            end
         end
      end
      vectors++;
      if (refs != 0) begin
         errors++; $display("FAIL refresh_starved: got %0d refreshes exp 0", refs);
      end
      vid_req = 0;
      found = 0; reads_after = 0;
      for (int i = 0; i < 15 && !found; i++) begin
         tick;
         if (r_mem_read) reads_after++;
         if (r_mem_refresh) found = 1;
      end
      vectors++;
      if (!found || reads_after != 0 || r_overrun !== 1'b1) begin
         errors++; $display("FAIL refresh_release: got found %b reads %0d ovr %b exp 1 0 1",
                            found, reads_after, r_overrun);
      end
      for (int i = 0; i < 8; i++) tick;
   endtask

   task automatic test_reset_mid_read;
      logic found;
      int vcount;
      do_reset;
      mem_dout32 = 32'h0BADF00D;
      vid_req = 1; vid_addr = 23'h000300; vid_size = 2'b01;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (mem_read) found = 1; end
      vid_req = 0;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (vid_valid) found = 1; end
      vectors++;
      if (!found || vid_data !== 32'h0BADF00D) begin
         errors++; $display("FAIL pre_reset_read: got valid %b data %h exp 1 0badf00d", found, vid_data);
      end
      tick;
      vid_req = 1;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin tick; if (mem_read) found = 1; end
      vid_req = 0;
      tick; tick;
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({mem_read, vid_ack, vid_valid, mem_addr, mem_word_size, vid_data} !== 60'b0) begin
         errors++; $display("FAIL async_reset_mid_read: got rd %b ack %b v %b addr %h size %b data %h exp 0",
                            mem_read, vid_ack, vid_valid, mem_addr, mem_word_size, vid_data);
      end
      tick;
      reset = 1'b0;
      vcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (vid_valid | mem_read) vcount++;
      end
      vectors++;
      if (vcount != 0) begin
         errors++; $display("FAIL abandoned_read: got %0d valid/read cycles exp 0", vcount);
      end
   endtask

   initial begin
      test_reset;
      test_vid_read;
      test_cpu_read;
      test_cmd;
      test_back_to_back;
      test_refresh_starvation;
      test_reset_mid_read;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FREQ, default 54_000_000, system clock frequency in Hz (informational, passed down for consistency).
REQ-002 SHALL have parameter REFRESH_INTERVAL, default 405, clk cycles between auto-refresh requests (7.5 us at 54 MHz).
REQ-003 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
REQ-004 SHALL have video port: vid_req in 1 request level; vid_addr in 23 byte address; vid_size in 2 word size (01=16, 10=32); vid_ack out 1 grant pulse; vid_valid out 1 read-data pulse; vid_data out 32 read data.
REQ-005 SHALL have CPU port: cpu_req in 1; cpu_wr in 1 (1=write); cpu_addr in 23; cpu_din8 in 8; cpu_ack out 1; cpu_valid out 1; cpu_data out 8.
REQ-006 SHALL have command port: cmd_req in 1; cmd_wr in 1; cmd_addr in 23; cmd_size in 2; cmd_din8 in 8; cmd_din32 in 32; cmd_ack out 1; cmd_valid out 1; cmd_data out 32.
REQ-007 SHALL have memory-controller port: mem_read, mem_write, mem_refresh out 1 each; mem_addr out 23; mem_word_size out 2; mem_din8 out 8; mem_din32 out 32; mem_busy in 1; mem_enabled in 1; mem_dout16 in 16; mem_dout32 in 32.
REQ-008 SHALL have refresh_overrun out 1, sticky refresh-starvation flag.

Function
REQ-009 Word-size encoding SHALL be 00=8-bit, 01=16-bit, 10=32-bit; 11 SHALL be forwarded unchanged and not checked.
REQ-010 FSM SHALL have states IDLE and WAIT; IDLE -> WAIT on an issue, WAIT -> IDLE in the first cycle mem_busy is 0.
REQ-011 An issue SHALL occur only in IDLE, with mem_busy=0 and mem_enabled=1, and SHALL assert exactly one of mem_read/mem_write/mem_refresh for exactly one cycle.
REQ-012 Grant priority per issue SHALL be: video > pending refresh > command/CPU.
REQ-013 Command and CPU SHALL alternate round-robin when both request; the last-granted of the two SHALL lose a tie; the pointer SHALL reset to "CPU last".
REQ-014 The granted port's ack SHALL pulse for one cycle in the issue cycle; a requester SHALL hold req and its inputs until ack and may reassert in the cycle after ack.
REQ-015 Video issues SHALL be reads with mem_word_size=vid_size.
REQ-016 CPU reads SHALL issue as 16-bit; CPU writes SHALL issue as 8-bit with mem_din8=cpu_din8.
REQ-017 Command writes with cmd_size=01 SHALL issue as 8-bit using cmd_din8; all other command sizes SHALL pass through with din8/din32 as given.
REQ-018 The refresh counter SHALL count 0..REFRESH_INTERVAL-1 continuously and wrap; at wrap it SHALL set refresh_pending.
REQ-019 refresh_pending SHALL clear when a refresh is issued.
REQ-020 If the counter wraps while refresh_pending is already 1, refresh_overrun SHALL set and hold until reset; pending SHALL remain a single flag, not a count.
REQ-021 For a read, on the WAIT -> IDLE cycle the arbiter SHALL register the data to the owning port and pulse its valid for one cycle in the following cycle.
REQ-022 Captured read data: vid_data = mem_dout32; cmd_data = mem_dout32; cpu_data = cpu_addr[0] ? mem_dout16[15:8] : mem_dout16[7:0], using the captured address.
REQ-023 Latency: issue-to-valid SHALL equal controller busy time + 1 cycle; nominal total is 5 cycles from issue to valid.
REQ-024 A new issue SHALL NOT occur in the same cycle as the WAIT -> IDLE transition; back-to-back issue spacing SHALL be at least one idle cycle.
REQ-025 While mem_enabled=0, no issue SHALL occur; the refresh counter SHALL keep running.
REQ-026 Writes and refreshes SHALL produce no valid pulse.
REQ-027 Data outputs SHALL hold their last captured value between valid pulses.

Reset
REQ-028 While reset is 1, the block SHALL asynchronously force: state IDLE; all mem_* strobes 0; mem_addr, mem_word_size, mem_din8, mem_din32 0; all ack/valid 0; vid_data, cpu_data, cmd_data 0; refresh counter 0; refresh_pending 0; refresh_overrun 0; round-robin pointer "CPU last".
REQ-029 Reset asserted during WAIT SHALL abandon the operation with no valid pulse.
REQ-030 After reset deasserts, the first issue SHALL wait for mem_enabled=1 and mem_busy=0.

Verification
REQ-031 Video 32-bit read at 0x000100, model busy for 4 cycles, returning 0xDEADBEEF -> mem_read pulse and vid_ack in same cycle; vid_valid one cycle after busy falls; vid_data=0xDEADBEEF.
REQ-032 CPU read at 0x000005 with mem_dout16=0xA55A -> mem_word_size=01; cpu_data=0xA5. Repeat at 0x000004 -> cpu_data=0x5A.
REQ-033 cmd_req and cpu_req held continuously as writes -> grants alternate CPU, CMD, CPU, CMD; no grant lands in the cycle busy falls.
REQ-034 REFRESH_INTERVAL=8, video requesting continuously -> refresh never issues; refresh_overrun=1 after the second wrap. Release vid_req -> mem_refresh issues next idle slot.
REQ-035 Command write with cmd_size=01, cmd_din8=0x3C -> mem_write with mem_word_size=00, mem_din8=0x3C.
REQ-036 Reset asserted mid-read -> outputs at reset values immediately; no valid pulse afterwards.
